// File: rtl/ext_sched.sv
// Two-requester round-robin scheduler for the shared 16->32-bit immediate extension unit.
// Optional grant counters are built when EXT_SCHED_STATS_EN is defined.
module ext_sched #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_imm,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_imm,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [OUT_W-1:0] rsp_data,
  output logic [15:0]      stat0_cnt,
  output logic [15:0]      stat1_cnt
);

  localparam int unsigned SEXT_W = OUT_W - IN_W;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q;
  logic [OUT_W-1:0]  rsp_data_q;
  logic [OUT_W-1:0]  rsp_data_d;
  logic              rsp_id_q;
  logic              last_gnt_q;
  logic              can_accept_c;
  logic              gnt0_c;
  logic              gnt1_c;
  logic [IN_W-1:0]   sel_imm_c;
  logic [1:0]        sel_op_c;
  logic [OUT_W-1:0]  zext_c;
  logic [OUT_W-1:0]  sext_c;

  // Grant: a lone valid wins; on contention the requester not granted last wins.
  assign can_accept_c = (state_q == EMPTY) | rsp_ready;
  assign gnt0_c = can_accept_c & req0_valid & (~req1_valid | last_gnt_q);
  assign gnt1_c = can_accept_c & req1_valid & (~req0_valid | ~last_gnt_q);

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // Extension of the granted request; feeds only the response register.
  always_comb begin
    sel_imm_c  = gnt1_c ? req1_imm : req0_imm;
    sel_op_c   = gnt1_c ? req1_op  : req0_op;
    zext_c     = OUT_W'(sel_imm_c);
    sext_c     = {{SEXT_W{sel_imm_c[IN_W-1]}}, sel_imm_c};
    rsp_data_d = zext_c;
    case (sel_op_c)
      2'b00:   rsp_data_d = zext_c;
      2'b01:   rsp_data_d = sext_c;
      2'b10:   rsp_data_d = zext_c << 16;
      default: rsp_data_d = sext_c << 2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (gnt0_c | gnt1_c) begin
            state_q    <= FULL;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= gnt1_c;
            last_gnt_q <= gnt1_c;
          end
        end
        default: begin
          if (gnt0_c | gnt1_c) begin
            state_q    <= FULL;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= gnt1_c;
            last_gnt_q <= gnt1_c;
          end else if (rsp_ready) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef EXT_SCHED_STATS_EN
  logic [15:0] stat0_cnt_q;
  logic [15:0] stat1_cnt_q;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_cnt_q <= '0;
      stat1_cnt_q <= '0;
    end else begin
      if (gnt0_c && (stat0_cnt_q != CNT_MAX)) stat0_cnt_q <= stat0_cnt_q + 16'd1;
      if (gnt1_c && (stat1_cnt_q != CNT_MAX)) stat1_cnt_q <= stat1_cnt_q + 16'd1;
    end
  end

  assign stat0_cnt = stat0_cnt_q;
  assign stat1_cnt = stat1_cnt_q;
`else
  assign stat0_cnt = 16'd0;
  assign stat1_cnt = 16'd0;
`endif

endmodule
